uart_rx_mmio: RTL and testbench

Memory-mapped UART receiver for the picorv32 SoC, the receive-side counterpart to the existing transmit path on the `txd` pin. It samples the asynchronous `rxd` line (8N1, LSB first) and buffers received bytes in a small FIFO. The core reads them as a responder on the picorv32 native memory bus. It sits inside `top`, beside the UART transmitter, with `mem_sel` decoded upstream from the address map.

---
 rtl/uart_rx_mmio.sv | 155 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// UART receiver (8N1, LSB first) with a receive FIFO, exposed as a responder
// on the picorv32 native memory bus: DATA / DIV / STATUS registers.
module uart_rx_mmio #(
  parameter int DIV_RESET  = 1085,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  input  logic        mem_valid,
  input  logic        mem_sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        rx_irq
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for rxd_s low
  // S_START | timing to the centre of the start bit
  // S_DATA  | sampling data bits 0..7
  // S_STOP  | timing to the centre of the stop bit
  // S_BREAK | framing error, waiting for the line to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          rxd_m, rxd_s;
  state_t        state;
  logic [15:0]   tmr, div, div_new;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overrun, frame_err;
  logic          accept, is_read, pop, push_req, do_push, fifo_full, fifo_nempty;
  logic          tmr_exp, stop_bad, div_wr, stat_wr;
  logic [1:0]    reg_sel;
  logic [4:0]    count5;
  logic [31:0]   rd_val;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign tmr_exp  = (tmr == 16'd0);
  assign push_req = (state == S_STOP) && tmr_exp && rxd_s;
  assign stop_bad = (state == S_STOP) && tmr_exp && !rxd_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      tmr   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (!tmr_exp) tmr <= tmr - 16'd1;
      case (state)
        S_IDLE: if (!rxd_s) begin
          // start-bit centre lands div>>1 clocks after the falling edge
          tmr   <= (div >> 1) - 16'd1;
          state <= S_START;
        end
        S_START: if (tmr_exp) begin
          if (!rxd_s) begin
            tmr   <= div - 16'd1;
            idx   <= '0;
            state <= S_DATA;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: if (tmr_exp) begin
          shreg[idx] <= rxd_s;
          tmr        <= div - 16'd1;
          idx        <= idx + 3'd1;
          if (idx == 3'd7) state <= S_STOP;
        end
        S_STOP:  if (tmr_exp) state <= rxd_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rxd_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign accept      = mem_valid && mem_sel && !mem_ready;
  assign is_read     = (mem_wstrb == 4'b0000);
  assign reg_sel     = mem_addr[3:2];
  assign fifo_full   = (count == CW'(FIFO_DEPTH));
  assign fifo_nempty = (count != '0);
  assign pop         = accept && is_read && (reg_sel == 2'd0) && fifo_nempty;
  assign do_push     = push_req && !fifo_full;
  assign div_wr      = accept && !is_read && (reg_sel == 2'd1) && (mem_wstrb[1:0] != 2'b00);
  assign stat_wr     = accept && !is_read && (reg_sel == 2'd2) && mem_wstrb[0];
  assign count5      = 5'(count);

  always_comb begin
    div_new = div;
    if (mem_wstrb[0]) div_new[7:0]  = mem_wdata[7:0];
    if (mem_wstrb[1]) div_new[15:8] = mem_wdata[15:8];
    if (div_new < 16'd4) div_new = 16'd4;
  end

  always_comb begin
    rd_val = 32'h0;
    case (reg_sel)
      2'd0:    rd_val = fifo_nempty ? {24'h0, fifo_mem[rd_ptr]} : 32'hFFFF_FFFF;
      2'd1:    rd_val = {16'h0, div};
      2'd2:    rd_val = {23'h0, count5, frame_err, overrun, fifo_full, fifo_nempty};
      default: rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      div       <= 16'(DIV_RESET);
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(pop);
      // set beats a same-cycle write-1-to-clear
      if (push_req && fifo_full)             overrun <= 1'b1;
      else if (stat_wr && mem_wdata[2])      overrun <= 1'b0;
      if (stop_bad)                          frame_err <= 1'b1;
      else if (stat_wr && mem_wdata[3])      frame_err <= 1'b0;
      if (div_wr) div <= div_new;
      mem_ready <= accept;
      mem_rdata <= (accept && is_read) ? rd_val : 32'h0;
    end
  end

  assign rx_irq = fifo_nempty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: bit-banged serial frames against a
// queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx_mmio;
  localparam int DIV_RST = 40;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rxd = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_sel = 1'b0;
  logic [3:0]  mem_addr = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rx_irq;

  int errors = 0;
  int checks = 0;
  int cur_div = DIV_RST;
  logic [7:0] exp_q[$];
  bit m_ovr = 0;
  bit m_fe = 0;

  uart_rx_mmio #(.DIV_RESET(DIV_RST), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(exp_q.size());
    return {23'h0, c, m_fe, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  task automatic bus_xfer(input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata);
    bit got;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    got = 0;
    rdata = 32'hDEAD_BEEF;
    for (int n = 0; n < 10 && !got; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1; rdata = mem_rdata; end
    end
    mem_valid = 1'b0; mem_sel = 1'b0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_timeout addr=%0h: mem_ready never seen, required one pulse", addr);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_xfer(addr, wdata, strb, dummy);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    repeat (cur_div) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (cur_div) @(posedge clk);
    end
    rxd = stop;
    repeat (cur_div) @(posedge clk);
    if (stop) begin
      if (exp_q.size() == DEPTH) m_ovr = 1;
      else exp_q.push_back(b);
      repeat (4) @(posedge clk);
    end else begin
      m_fe = 1;
    end
  endtask

  task automatic check_data(input string name);
    logic [31:0] d, e;
    e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
    bus_xfer(4'h0, 32'h0, 4'h0, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: data read got %h, required %h", name, d, e);
    end
  endtask

  task automatic check_status(input string name);
    logic [31:0] d, e;
    e = m_status();
    bus_xfer(4'h8, 32'h0, 4'h0, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: status got %h, required %h", name, d, e);
    end
  endtask

  task automatic check_div(input string name, input logic [31:0] e);
    logic [31:0] d;
    bus_xfer(4'h4, 32'h0, 4'h0, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: div got %h, required %h", name, d, e);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, mem_rdata, rx_irq} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b, required all 0",
               mem_ready, mem_rdata, rx_irq);
    end
    resetn = 1'b1;
    check_status("reset_status");
    check_div("reset_div", DIV_RST);
    check_data("reset_empty_read");
  endtask

  task automatic test_basic();
    bus_write(4'h4, 32'd16, 4'b0011);
    cur_div = 16;
    check_div("div16", 32'd16);
    send_frame(8'hA5, 1);
    send_frame(8'h3C, 1);
    check_data("basic_a5");
    checks++;
    if (rx_irq !== 1'b1) begin errors++; $display("FAIL basic_irq_one_left: got %b, required 1", rx_irq); end
    check_data("basic_3c");
    checks++;
    if (rx_irq !== 1'b0) begin errors++; $display("FAIL basic_irq_fall: got %b, required 0", rx_irq); end
    check_data("basic_empty");
  endtask

  task automatic test_glitch();
    @(posedge clk); #1; rxd = 1'b0;
    @(posedge clk); #1; rxd = 1'b1;
    repeat (40) @(posedge clk);
    check_status("glitch_status");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) send_frame(8'($urandom), 1);
      #1;
      checks++;
      if (rx_irq !== 1'b1) begin errors++; $display("FAIL rand_irq: got %b, required 1", rx_irq); end
      check_status("rand_status");
      for (int k = 0; k <= n; k++) check_data("rand_data");
    end
  endtask

  task automatic test_overrun();
    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1);
    check_status("overrun_status");
    for (int k = 0; k < DEPTH; k++) check_data("overrun_data");
    check_data("overrun_empty");
    bus_write(4'h8, 32'h4, 4'b0001);
    m_ovr = 0;
    check_status("overrun_cleared");
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 0);
    repeat (100) @(posedge clk);
    check_status("frame_err_status");
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h77, 1);
    check_data("frame_err_recover");
    bus_write(4'h8, 32'h8, 4'b0001);
    m_fe = 0;
    check_status("frame_err_cleared");
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [31:0] d, e;
    send_frame(8'($urandom), 1);
    send_frame(8'($urandom), 1);
    pulses = 0;
    d = 32'h0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin mem_valid = 1'b0; mem_sel = 1'b0; end
      if (mem_ready) begin pulses++; d = mem_rdata; end
    end
    e = {24'h0, exp_q.pop_front()};
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL b2b_pulses: got %0d, required 1", pulses); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL b2b_data: got %h, required %h", d, e); end
    check_status("b2b_count");
    check_data("b2b_second");
  endtask

  task automatic test_div();
    bus_write(4'h4, 32'h0000_0002, 4'b0011);
    check_div("div_clamp", 32'd4);
    bus_write(4'h4, 32'h0000_0020, 4'b1111);
    check_div("div32", 32'h20);
    bus_write(4'h4, 32'hFFFF_0140, 4'b0010);
    check_div("div_strobe_hi", 32'h0120);
    bus_write(4'h4, 32'h0000_0020, 4'b0011);
    cur_div = 32;
    send_frame(8'($urandom), 1);
    send_frame(8'($urandom), 1);
    check_data("div32_data0");
    check_data("div32_data1");
  endtask

  task automatic test_reset_mid();
    send_frame(8'h5A, 1);
    rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_ready, mem_rdata, rx_irq} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b rdata=%h irq=%b, required all 0",
               mem_ready, mem_rdata, rx_irq);
    end
    exp_q.delete();
    m_ovr = 0; m_fe = 0;
    cur_div = DIV_RST;
    rxd = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (100) @(posedge clk);
    check_div("reset_mid_div", DIV_RST);
    check_status("reset_mid_status");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_random();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_div();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule
